// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares a single UART transmitter
// between N_REQ byte producers. One requester is granted at a time; its byte
// and parity settings are latched on the grant edge and held until the next
// grant. Frame completion is tracked through the transmitter's busy flag, and
// a frame whose busy never rises is abandoned after BUSY_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_par_en,
  input  logic [N_REQ-1:0]              req_par_typ,
  output logic [N_REQ-1:0]              req_ack,
  output logic [N_REQ-1:0]              req_done,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_data_valid,
  output logic                          tx_par_en,
  output logic                          tx_par_typ,
  input  logic                          tx_busy,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [CNT_W-1:0]  busy_cnt;

  logic              hi_found;
  logic              lo_found;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin pick: lowest requester above 'last' wins, otherwise wrap to
  // the lowest requester at or below 'last'. Scanning downward lets the
  // lowest matching index overwrite earlier hits.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = ID_W'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Arbiter FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      last          <= ID_W'(N_REQ - 1);
      busy_cnt      <= '0;
      grant_id      <= '0;
      tx_p_data     <= '0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= 1'b0;
      tx_data_valid <= 1'b0;
      req_ack       <= '0;
      req_done      <= '0;
      arb_busy      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      req_ack       <= '0;
      req_done      <= '0;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          // An external frame still on the line blocks any new grant.
          if (pick_found && !tx_busy) begin
            state         <= ISSUE;
            grant_id      <= pick_idx;
            last          <= pick_idx;
            tx_p_data     <= req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            tx_par_en     <= req_par_en[pick_idx];
            tx_par_typ    <= req_par_typ[pick_idx];
            tx_data_valid <= 1'b1;
            req_ack       <= onehot(pick_idx);
            arb_busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state    <= WAIT_BUSY;
          busy_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never picked the byte up: drop it, keep 'last'
            // advanced so the next requester gets the following turn.
            state       <= IDLE;
            timeout_err <= 1'b1;
            arb_busy    <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state    <= IDLE;
            req_done <= onehot(grant_id);
            arb_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of round-robin vectors, hand-written
// corner sequences (single frame, timeout, external busy, reset mid-frame)
// and a randomized phase checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  req_valid   = '0;
  logic [31:0] req_data    = '0;
  logic [3:0]  req_par_en  = '0;
  logic [3:0]  req_par_typ = '0;
  logic [3:0]  req_ack;
  logic [3:0]  req_done;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;

  int n_cmp      = 0;
  int n_err      = 0;
  int model_last = N_REQ - 1;

  typedef struct {
    logic [3:0] v;
    int         exp_id;
    int         busy_len;
  } vec_t;
  vec_t tbl[12];

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_typ(req_par_typ),
    .req_ack(req_ack), .req_done(req_done),
    .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
    .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ),
    .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before 400us");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference rule: first requesting index after 'last', wrapping modulo N_REQ.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (((v >> ((last + k) % N_REQ)) & 4'd1) != 4'd0) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ack"},       32'(req_ack),       32'd0);
    check({tag, "_req_done"},      32'(req_done),      32'd0);
    check({tag, "_tx_p_data"},     32'(tx_p_data),     32'd0);
    check({tag, "_tx_data_valid"}, 32'(tx_data_valid), 32'd0);
    check({tag, "_tx_par"},        32'({tx_par_en, tx_par_typ}), 32'd0);
    check({tag, "_grant_id"},      32'(grant_id),      32'd0);
    check({tag, "_arb_busy"},      32'(arb_busy),      32'd0);
    check({tag, "_timeout_err"},   32'(timeout_err),   32'd0);
  endtask

  // One transaction: present requests in IDLE, expect ISSUE on the next cycle,
  // then either emulate the transmitter for busy_len cycles or let it time out.
  task automatic do_frame(input logic [3:0] v, input logic [31:0] d, input logic [3:0] pe,
                          input logic [3:0] pt, input int exp_id, input int busy_len,
                          input bit to_mode);
    int         k;
    int         got_k;
    logic [7:0] exp_byte;
    req_valid   = v;
    req_data    = d;
    req_par_en  = pe;
    req_par_typ = pt;
    exp_byte    = d[exp_id*8 +: 8];
    got_k       = -1;
    for (k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (req_ack != 4'd0) begin
        got_k = k;
        break;
      end
    end
    check("issue_latency", 32'(got_k), 32'd0);
    if (got_k < 0) begin
      req_valid = '0;
      return;
    end
    check("req_ack",       32'(req_ack),       32'(1) << exp_id);
    check("grant_id",      32'(grant_id),      32'(exp_id));
    check("tx_data_valid", 32'(tx_data_valid), 32'd1);
    check("tx_p_data",     32'(tx_p_data),     32'(exp_byte));
    check("tx_par_en",     32'(tx_par_en),     32'(pe[exp_id]));
    check("tx_par_typ",    32'(tx_par_typ),    32'(pt[exp_id]));
    check("arb_busy_issue", 32'(arb_busy),     32'd1);
    model_last = exp_id;
    if (to_mode) begin
      got_k = -1;
      for (k = 1; k <= BUSY_TIMEOUT + 3; k++) begin
        @(negedge CLK);
        if (req_done != 4'd0) check("no_done_on_timeout", 32'(req_done), 32'd0);
        if (timeout_err) begin
          got_k = k;
          break;
        end
      end
      check("timeout_cycles", 32'(got_k), 32'(BUSY_TIMEOUT + 1));
      check("arb_busy_after_timeout", 32'(arb_busy), 32'd0);
    end else begin
      @(negedge CLK);
      tx_busy = 1'b1;
      check("dv_low_wait_busy", 32'(tx_data_valid), 32'd0);
      for (k = 0; k < busy_len; k++) begin
        @(negedge CLK);
        if (k == 0) req_data[exp_id*8 +: 8] = ~exp_byte;
        if (tx_p_data !== exp_byte || tx_data_valid !== 1'b0 || req_done !== 4'd0) begin
          check("frame_hold", {tx_p_data, 3'd0, tx_data_valid, req_done, 16'd0},
                {exp_byte, 24'd0});
        end
      end
      check("tx_p_data_stable", 32'(tx_p_data), 32'(exp_byte));
      tx_busy = 1'b0;
      @(negedge CLK);
      check("req_done",       32'(req_done),    32'(1) << exp_id);
      check("arb_busy_done",  32'(arb_busy),    32'd0);
      check("no_timeout_err", 32'(timeout_err), 32'd0);
    end
    req_valid = '0;
  endtask

  initial begin
    logic [3:0]  v;
    logic [31:0] d;
    int          exp_id;

    tbl[0]  = '{4'b1011, 0, 3};
    tbl[1]  = '{4'b1011, 1, 2};
    tbl[2]  = '{4'b1011, 3, 5};
    tbl[3]  = '{4'b1011, 0, 1};
    tbl[4]  = '{4'b1011, 1, 4};
    tbl[5]  = '{4'b1011, 3, 2};
    tbl[6]  = '{4'b0100, 2, 3};
    tbl[7]  = '{4'b0110, 1, 2};
    tbl[8]  = '{4'b1001, 3, 6};
    tbl[9]  = '{4'b1111, 0, 2};
    tbl[10] = '{4'b0001, 0, 1};
    tbl[11] = '{4'b1000, 3, 3};

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Round-robin table
    for (int i = 0; i < 12; i++) begin
      do_frame(tbl[i].v, $urandom, 4'($urandom), 4'($urandom), tbl[i].exp_id,
               tbl[i].busy_len, 1'b0);
    end

    // Single request, 11-cycle busy
    d = $urandom;
    d[7:0] = 8'hA5;
    do_frame(4'b0001, d, 4'b0001, 4'b0000, 0, 11, 1'b0);

    // Timeout, then next requester gets the grant
    do_frame(4'b1111, $urandom, 4'b1010, 4'b0110, 1, 0, 1'b1);
    do_frame(4'b1111, $urandom, 4'b1111, 4'b0100, 2, 2, 1'b0);

    // External busy blocks the grant
    tx_busy   = 1'b1;
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("ext_busy_no_ack",  32'(req_ack),  32'd0);
      check("ext_busy_no_arb",  32'(arb_busy), 32'd0);
    end
    tx_busy = 1'b0;
    do_frame(4'b0100, $urandom, 4'b0100, 4'b0100, 2, 2, 1'b0);

    // Reset during WAIT_DONE
    req_valid = 4'b0010;
    req_data  = 32'h1234_5678;
    req_par_en  = 4'b0010;
    req_par_typ = 4'b0010;
    @(negedge CLK);
    check("rst_seq_ack", 32'(req_ack), 32'b0010);
    req_valid = '0;
    @(negedge CLK);
    tx_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_seq_busy_before", 32'(arb_busy), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("midreset");
    tx_busy   = 1'b0;
    req_valid = 4'b1111;
    @(negedge CLK);
    check("midreset_no_done", 32'(req_done), 32'd0);
    RST = 1'b1;
    model_last = N_REQ - 1;
    do_frame(4'b1111, $urandom, 4'b0001, 4'b0001, 0, 3, 1'b0);

    // Randomized transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      v      = 4'($urandom_range(1, 15));
      exp_id = rr_pick(v, model_last);
      do_frame(v, $urandom, 4'($urandom), 4'($urandom), exp_id,
               $urandom_range(1, 12), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. It grants one requester at a time and holds that requester's byte and parity configuration stable for the whole frame. It drives the transmitter's data-valid strobe and tracks the transmitter's busy flag to detect frame completion. It sits directly in front of the UART TX top level; requesters never touch the transmitter.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, byte width, matches transmitter `P_DATA`
- `BUSY_TIMEOUT`, 4, max cycles in WAIT_BUSY for busy to rise before abort (≥1)

- `CLK` in 1: single clock, all state on rising edge
- `RST` in 1: asynchronous, active-low reset
- `req_valid` in N_REQ: level request per requester
- `req_data` in N_REQ*DATA_WIDTH: packed bytes, requester i at [DATA_WIDTH*i +: DATA_WIDTH]
- `req_par_en` in N_REQ: per-requester parity enable
- `req_par_typ` in N_REQ: per-requester parity type (0 even, 1 odd)
- `req_ack` out N_REQ: one-hot, 1-cycle pulse, byte captured
- `req_done` out N_REQ: one-hot, 1-cycle pulse, frame finished on line
- `tx_p_data` out DATA_WIDTH: to transmitter `P_DATA`
- `tx_data_valid` out 1: to transmitter `Data_valid`
- `tx_par_en` out 1: to transmitter `PAR_EN`
- `tx_par_typ` out 1: to transmitter `PAR_TYP`
- `tx_busy` in 1: from transmitter `busy`
- `grant_id` out clog2(N_REQ): index of current/last granted requester
- `arb_busy` out 1: high in any state except IDLE
- `timeout_err` out 1: 1-cycle pulse on busy-rise timeout

## Operation
- All outputs registered. Reset values: every output 0; state IDLE; round-robin pointer `last` = N_REQ-1 (requester 0 wins first); timeout counter 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `req_valid` and `tx_busy`=0, pick the first set bit searching from (last+1) mod N_REQ upward with wrap. Capture its byte, par_en, par_typ into `tx_*` regs, set `grant_id`, `last` = winner -> ISSUE. If `tx_busy`=1, no grant.
- ISSUE (exactly 1 cycle): `tx_data_valid`=1, `req_ack[grant_id]`=1 -> WAIT_BUSY, counter cleared.
- WAIT_BUSY: `tx_busy`=1 -> WAIT_DONE. Otherwise counter+1; when counter reaches BUSY_TIMEOUT -> IDLE with `timeout_err` pulse, no `req_done`, `last` still advanced.
- WAIT_DONE: stay while `tx_busy`=1; on `tx_busy`=0 -> IDLE with `req_done[grant_id]` pulse.
- `tx_p_data`, `tx_par_en`, `tx_par_typ` change only on the grant edge; they are stable from ISSUE until the next grant.
- Request data is sampled only on the grant edge. A requester dropping `req_valid` before grant is skipped silently. A requester keeping `req_valid` after ack is treated as a new request.
- Non-granted requesters wait; each requester is served at most once per N_REQ grants while others are pending.
- Reset mid-frame: all outputs and state return to reset values asynchronously. No `req_done` is issued for the aborted frame.

## Timing
- Request visible at edge k (IDLE) -> ISSUE cycle k+1 (`tx_data_valid`, `req_ack`) -> WAIT_BUSY from k+2.
- Transmitter raises busy one cycle after Data_valid, so a normal frame leaves WAIT_BUSY after 1 cycle.
- `tx_busy` falls, sampled at edge f -> `req_done` and IDLE during cycle f+1 -> next ISSUE at f+2 at the earliest (gap of 1 IDLE cycle).
- `timeout_err` is asserted in the first IDLE cycle after BUSY_TIMEOUT WAIT_BUSY cycles.
- `tx_data_valid` is never high for more than 1 consecutive cycle, and never high while the arbiter is in WAIT_BUSY or WAIT_DONE.

## Test plan
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, par_en=1, par_typ=0 -> ISSUE with tx_p_data=8'hA5, tx_par_en=1, req_ack=4'b0001. Model busy high 11 cycles -> req_done=4'b0001 one cycle after busy falls.
- Round-robin: hold req_valid=4'b1011 continuously -> grant order 0,1,3,0,1,3; req_ack one-hot each time; no back-to-back ISSUE without a WAIT_DONE between.
- Data stability: change req_data of the granted requester during WAIT_DONE -> tx_p_data unchanged until the next grant.
- Timeout with BUSY_TIMEOUT=4: tie tx_busy=0 -> timeout_err pulses 4 cycles after WAIT_BUSY entry, no req_done, and the next grant goes to the next requester.
- External busy: tx_busy=1 while in IDLE with req_valid=4'b0100 -> no grant. Drop busy -> ISSUE 1 cycle later.
- Reset mid-frame: RST low during WAIT_DONE -> all outputs 0 immediately. After release with req_valid=4'b1111 -> requester 0 granted first.
